final_project_bcd_counter: RTL and testbench
============================================

# final_project_bcd_counter

Four-digit BCD up/down counter that drives the per-digit seven-segment decoders on the DE2 HEX displays. It counts on debounced button pulses, on an internal prescaled timer tick, or both, and supports parallel load. Each 4-bit digit output feeds one decoder instance directly. Every digit output is always in the range 0–9, so no decoder ever falls into its default case.

## Interface
- TICK_DIV, 50_000_000: clk cycles per timer step (1 Hz at 50 MHz). Legal range ≥ 2.
- WRAP, 1: 1 = wrap at the limits (9999↔0000); 0 = saturate at the limits.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  enables the timer prescaler and timer steps.
- inc  input  1  level input from a debounced button; each 0→1 transition is one step.
- dir  input  1  0 = count up, 1 = count down; applies to every step.
- load  input  1  loads load_val on the next edge.
- load_val  input  16  BCD value; [15:12] thousands … [3:0] ones.
- digit0  output  4  ones digit.
- digit1  output  4  tens digit.
- digit2  output  4  hundreds digit.
- digit3  output  4  thousands digit.
- zero  output  1  high when the count is 0000.
- max  output  1  high when the count is 9999.
- tick  output  1  one-cycle pulse, high in the cycle after a timer step is applied.

## Operation
- State: four 4-bit BCD digit registers, a prescaler counter sized to ceil(log2(TICK_DIV)) bits, an inc history register inc_q, and a tick register.
- Edge detect: inc_rise = inc & ~inc_q. inc_q samples inc every cycle.
- Timer step: raised when en = 1 and prescaler = TICK_DIV−1.
  - Prescaler increments when en = 1, wraps to 0 at TICK_DIV−1, and holds its value when en = 0.
- Step request: inc_rise OR timer step. If both occur in the same cycle, exactly one step is applied.
- Priority per edge: rst > load > step > hold.
  - load: each digit takes its load_val nibble. Any nibble > 9 is clamped to 9. The prescaler clears to 0. Any step in that cycle is discarded.
  - Step up: BCD increment with ripple carry. A digit at 9 goes to 0 and carries into the next digit.
  - Step down: BCD decrement with ripple borrow. A digit at 0 goes to 9 and borrows from the next digit.
  - Up at 9999: WRAP = 1 → 0000; WRAP = 0 → stays at 9999.
  - Down at 0000: WRAP = 1 → 9999; WRAP = 0 → stays at 0000.
- dir is sampled on the same edge that applies the step.
- zero and max decode directly from the digit registers, with no extra latency.

## Timing
- Reset values (edge with rst = 1):
  - digit0–digit3 = 0, so zero = 1 and max = 0.
  - Prescaler = 0, tick = 0.
  - inc_q = 1, so an inc held high through reset does not produce a step.
- inc latency:
  - The digits update on the first edge that samples inc = 1 after an edge that sampled inc = 0.
  - A held inc produces exactly one step.
  - A 1-cycle inc pulse is counted.
- Timer latency:
  - With en = 1 continuously from prescaler = 0, steps are applied on edges TICK_DIV, 2·TICK_DIV, and so on.
  - tick is high during the cycle following each such edge.
- Load latency: the digits equal the clamped load_val after 1 edge. tick is not asserted for a load.
- Deasserting en mid-count freezes the prescaler. Re-asserting en resumes from the frozen value; the prescaler does not restart.
- Asserting rst mid-count overrides load and step in that cycle.

## Test plan
- Reset, then 12 single-cycle inc pulses with dir = 0 → digits 0012; zero drops after the first pulse.
- Load 0x9998 with dir = 0 and WRAP = 1, then 3 inc pulses → 9999 (max = 1), then 0000 (zero = 1), then 0001. Repeat with WRAP = 0 → the count holds at 9999.
- dir = 1, load 0x1000, 1 inc pulse → 0999. Load 0x0000, 1 inc pulse with WRAP = 0 → stays 0000.
- TICK_DIV = 4, en = 1 from reset release, no inc → steps on edges 4, 8 and 12 give 0001, 0002, 0003. tick pulses in the cycle after each step. Drop en for 10 cycles → no change; raise en again → the next step follows after the remaining prescale count.
- inc rise coincident with a timer step → exactly +1. load asserted with an inc rise → the load value wins. load_val 0xA5F3 → 9593.
- inc held high across rst deassert → no step. rst asserted mid-count → 0000 on the next edge.

Source files
------------

// File: rtl/final_project_bcd_counter.sv
// Four-digit BCD up/down counter feeding the HEX display decoders.
// Steps on debounced inc rising edges and/or a prescaled timer; supports clamped parallel load.
module final_project_bcd_counter #(
    parameter int TICK_DIV = 50_000_000,
    parameter bit WRAP     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        inc,
    input  logic        dir,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [3:0]  digit0,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic [3:0]  digit3,
    output logic        zero,
    output logic        max,
    output logic        tick
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [3:0][3:0] digits;
    logic [3:0][3:0] digits_step;
    logic [3:0][3:0] digits_load;
    logic [PW-1:0]   presc;
    logic            inc_q;
    logic            inc_rise;
    logic            timer_step;
    logic            step_req;
    logic            carry;
    logic            at_max;
    logic            at_zero;

    function automatic logic [3:0] clamp9(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    assign inc_rise   = inc & ~inc_q;
    assign timer_step = en && (presc == PRESC_LAST);
    assign step_req   = inc_rise | timer_step;

    assign at_max  = (digits == 16'h9999);
    assign at_zero = (digits == 16'h0000);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            digits_load[i] = clamp9(load_val[4*i +: 4]);
        end
    end

    // Ripple carry/borrow: 9999 up and 0000 down fall out as wrap naturally.
    always_comb begin
        digits_step = digits;
        carry       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (!dir) begin
                    if (digits[i] == 4'd9) begin
                        digits_step[i] = 4'd0;
                    end else begin
                        digits_step[i] = digits[i] + 4'd1;
                        carry          = 1'b0;
                    end
                end else begin
                    if (digits[i] == 4'd0) begin
                        digits_step[i] = 4'd9;
                    end else begin
                        digits_step[i] = digits[i] - 4'd1;
                        carry          = 1'b0;
                    end
                end
            end
        end
        if (!WRAP && ((!dir && at_max) || (dir && at_zero))) begin
            digits_step = digits;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits <= '0;
            presc  <= '0;
            tick   <= 1'b0;
            inc_q  <= 1'b1;
        end else begin
            inc_q <= inc;
            if (load) begin
                digits <= digits_load;
                presc  <= '0;
                tick   <= 1'b0;
            end else begin
                if (en) begin
                    presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
                end
                tick <= timer_step;
                if (step_req) begin
                    digits <= digits_step;
                end
            end
        end
    end

    assign digit0 = digits[0];
    assign digit1 = digits[1];
    assign digit2 = digits[2];
    assign digit3 = digits[3];
    assign zero   = at_zero;
    assign max    = at_max;

endmodule

// File: tb/tb_final_project_bcd_counter.sv
// Randomized and directed bench for final_project_bcd_counter, wrapping and saturating builds side by side,
// checked against an integer-valued reference model.
module tb_final_project_bcd_counter;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst, en, inc, dir, load;
    logic [15:0] load_val;
    logic [3:0]  w0, w1, w2, w3, s0, s1, s2, s3;
    logic        wz, wm, wt, sz, sm, st;

    int n_checks = 0;
    int n_fail   = 0;

    int cnt_w, cnt_s, m_presc;
    bit m_inc_q, m_tick;

    always #5 clk = ~clk;

    final_project_bcd_counter #(.TICK_DIV(TD), .WRAP(1'b1)) dut_w (
        .clk(clk), .rst(rst), .en(en), .inc(inc), .dir(dir), .load(load), .load_val(load_val),
        .digit0(w0), .digit1(w1), .digit2(w2), .digit3(w3), .zero(wz), .max(wm), .tick(wt)
    );

    final_project_bcd_counter #(.TICK_DIV(TD), .WRAP(1'b0)) dut_s (
        .clk(clk), .rst(rst), .en(en), .inc(inc), .dir(dir), .load(load), .load_val(load_val),
        .digit0(s0), .digit1(s1), .digit2(s2), .digit3(s3), .zero(sz), .max(sm), .tick(st)
    );

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) begin
            int n = int'(v[4*i +: 4]);
            if (n > 9) n = 9;
            r = r * 10 + n;
        end
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int step_val(input int c, input bit down, input bit wrap);
        if (!down) return (c == 9999) ? (wrap ? 0 : 9999) : c + 1;
        return (c == 0) ? (wrap ? 9999 : 0) : c - 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_edge();
        bit ts, rise;
        if (rst) begin
            cnt_w = 0; cnt_s = 0; m_presc = 0; m_tick = 0; m_inc_q = 1;
        end else begin
            ts      = en && (m_presc == TD - 1);
            rise    = inc && !m_inc_q;
            m_inc_q = inc;
            if (load) begin
                cnt_w   = bcd2int(load_val);
                cnt_s   = cnt_w;
                m_presc = 0;
                m_tick  = 0;
            end else begin
                if (en) m_presc = (m_presc + 1) % TD;
                m_tick = ts;
                if (rise || ts) begin
                    cnt_w = step_val(cnt_w, dir, 1'b1);
                    cnt_s = step_val(cnt_s, dir, 1'b0);
                end
            end
        end
    endtask

    task automatic compare();
        check("wrap_digits", {16'h0, w3, w2, w1, w0}, {16'h0, int2bcd(cnt_w)});
        check("wrap_zero", wz, cnt_w == 0);
        check("wrap_max", wm, cnt_w == 9999);
        check("wrap_tick", wt, m_tick);
        check("sat_digits", {16'h0, s3, s2, s1, s0}, {16'h0, int2bcd(cnt_s)});
        check("sat_zero", sz, cnt_s == 0);
        check("sat_max", sm, cnt_s == 9999);
        check("sat_tick", st, m_tick);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse();
        inc = 1'b1; cycle();
        inc = 1'b0; cycle();
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; load_val = v; cycle();
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; inc = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
        cycle();
        check("reset_zero", wz, 1'b1);
        rst = 1'b0;
        cycle();

        // twelve up pulses
        for (int i = 0; i < 12; i++) pulse();
        check("count12", {16'h0, w3, w2, w1, w0}, 32'h0012);

        // wrap and saturate at the top
        do_load(16'h9998);
        for (int i = 0; i < 3; i++) pulse();
        check("wrap_top", {16'h0, w3, w2, w1, w0}, 32'h0001);
        check("sat_top", {16'h0, s3, s2, s1, s0}, 32'h9999);

        // down with borrow, then the bottom limit
        dir = 1'b1;
        do_load(16'h1000);
        pulse();
        check("borrow", {16'h0, w3, w2, w1, w0}, 32'h0999);
        do_load(16'h0000);
        pulse();
        check("sat_bottom", {16'h0, s3, s2, s1, s0}, 32'h0000);
        check("wrap_bottom", {16'h0, w3, w2, w1, w0}, 32'h9999);
        dir = 1'b0;

        // timer with en from reset release, then freeze and resume
        rst = 1'b1; en = 1'b1; cycle();
        rst = 1'b0;
        idle(13);
        check("timer3", {16'h0, w3, w2, w1, w0}, 32'h0003);
        en = 1'b0; idle(10);
        en = 1'b1; idle(8);

        // inc rise coincident with a timer step
        rst = 1'b1; cycle();
        rst = 1'b0; idle(3);
        inc = 1'b1; cycle();
        check("coincident", {16'h0, w3, w2, w1, w0}, 32'h0001);
        inc = 1'b0; cycle();

        // load wins over an inc rise; nibble clamp
        inc = 1'b1; do_load(16'hA5F3);
        check("clamp", {16'h0, w3, w2, w1, w0}, 32'h9593);
        inc = 1'b0; en = 1'b0; cycle();

        // inc held across reset deassert
        inc = 1'b1; rst = 1'b1; cycle();
        rst = 1'b0; idle(4);
        inc = 1'b0; cycle();
        pulse(); pulse();
        rst = 1'b1; cycle();
        rst = 1'b0; cycle();

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom % 100) == 0;
            load     = ($urandom % 25) == 0;
            inc      = ($urandom % 3) == 0;
            en       = ($urandom % 4) != 0;
            dir      = $urandom % 2;
            load_val = 16'($urandom);
            if (($urandom % 8) == 0) load_val = {4'd9, 4'd9, 4'd9, 4'($urandom % 10)};
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
